// File: rtl/instr_enc.sv
// rtl/instr_enc.sv - RISC-V immediate-format instruction encoder with 2-deep output FIFO
module instr_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ext_op,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [2:0] FmtI = 3'b000;
  localparam logic [2:0] FmtU = 3'b001;
  localparam logic [2:0] FmtS = 3'b010;
  localparam logic [2:0] FmtB = 3'b011;
  localparam logic [2:0] FmtJ = 3'b100;

  logic [31:0] encWord;
  logic        encErr;

  // FIFO entries hold {instr, err}; slot0 is always the head
  logic [32:0] slot0;
  logic [32:0] slot1;
  logic [1:0]  count;
  logic        doPush;
  logic        doPop;
  logic [15:0] encCount;
  logic [15:0] errCount;

  // A signed value fits in N bits when every bit from N-1 upward equals the sign
  logic fits12;
  logic fits13;
  logic fits21;
  assign fits12 = (imm[31:11] == {21{imm[31]}});
  assign fits13 = (imm[31:12] == {20{imm[31]}});
  assign fits21 = (imm[31:20] == {12{imm[31]}});

  // Build the instruction word and its error flag from the request fields
  always_comb begin
    encWord = {imm[11:0], rs1, funct3, rd, opcode};
    encErr  = 1'b0;
    case (ext_op)
      FmtI: begin
        encWord = {imm[11:0], rs1, funct3, rd, opcode};
        encErr  = !fits12;
      end
      FmtU: begin
        encWord = {imm[31:12], rd, opcode};
        encErr  = (imm[11:0] != 12'd0);
      end
      FmtS: begin
        encWord = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        encErr  = !fits12;
      end
      FmtB: begin
        encWord = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        encErr  = !fits13 || imm[0];
      end
      FmtJ: begin
        encWord = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        encErr  = !fits21 || imm[0];
      end
      default: begin
        // Unknown format: still deliver an I-shaped word, flagged as bad
        encWord = {imm[11:0], rs1, funct3, rd, opcode};
        encErr  = 1'b1;
      end
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? slot0[32:1] : 32'd0;
  assign out_err   = out_valid ? slot0[0] : 1'b0;
  assign doPush    = in_valid && in_ready;
  assign doPop     = out_valid && out_ready;

  // Two-entry in-order queue; push+pop together only happens at count 1
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= 33'd0;
      slot1 <= 33'd0;
    end else begin
      case ({doPush, doPop})
        2'b10: begin
          if (count == 2'd0) slot0 <= {encWord, encErr};
          else               slot1 <= {encWord, encErr};
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= 33'd0;
          count <= count - 2'd1;
        end
        2'b11: begin
          slot0 <= {encWord, encErr};
        end
        default: begin
        end
      endcase
    end
  end

  // Saturating accept and error counters
  always_ff @(posedge clk) begin
    if (rst) begin
      encCount <= 16'd0;
      errCount <= 16'd0;
    end else if (doPush) begin
      if (encCount != 16'hFFFF) encCount <= encCount + 16'd1;
      if (encErr && (errCount != 16'hFFFF)) errCount <= errCount + 16'd1;
    end
  end

  assign enc_cnt = encCount;
  assign err_cnt = errCount;

endmodule

// File: tb/tb_instr_enc.sv
// tb/tb_instr_enc.sv - scoreboard bench for instr_enc
module tb_instr_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ext_op;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_cnt;
  logic [15:0] err_cnt;

  instr_enc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ext_op(ext_op), .imm(imm), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
    bit          rt;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  int   nAsserts = 0;
  int   nFails = 0;
  int   nAcc = 0;
  int   nErr = 0;
  bit   monEn = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    nAsserts++;
    nFails++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic logic [31:0] modelEnc(input logic [2:0] f, input logic [31:0] v,
      input logic [6:0] opc, input logic [4:0] rdv, input logic [2:0] f3,
      input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] w;
    w = 32'd0;
    w[6:0] = opc;
    case (f)
      3'd1: begin w[31:12] = v[31:12]; w[11:7] = rdv; end
      3'd2: begin
        w[31:25] = v[11:5]; w[24:20] = r2; w[19:15] = r1; w[14:12] = f3; w[11:7] = v[4:0];
      end
      3'd3: begin
        w[31] = v[12]; w[30:25] = v[10:5]; w[24:20] = r2; w[19:15] = r1;
        w[14:12] = f3; w[11:8] = v[4:1]; w[7] = v[11];
      end
      3'd4: begin
        w[31] = v[20]; w[30:21] = v[10:1]; w[20] = v[11]; w[19:12] = v[19:12]; w[11:7] = rdv;
      end
      default: begin w[31:20] = v[11:0]; w[19:15] = r1; w[14:12] = f3; w[11:7] = rdv; end
    endcase
    return w;
  endfunction

  function automatic logic modelErr(input logic [2:0] f, input logic [31:0] v);
    int s;
    s = signed'(v);
    case (f)
      3'd0, 3'd2: return (s < -2048) || (s > 2047);
      3'd3:       return (s < -4096) || (s > 4094) || v[0];
      3'd4:       return (s < -1048576) || (s > 1048574) || v[0];
      3'd1:       return (v[11:0] != 12'd0);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'd1:    return {w[31:12], 12'd0};
      3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {{20{w[31]}}, w[31:20]};
    endcase
  endfunction

  task automatic present(input logic [2:0] f, input logic [31:0] v, input logic [6:0] opc,
      input logic [4:0] rdv, input logic [2:0] f3, input logic [4:0] r1,
      input logic [4:0] r2, input bit rt);
    ext_op = f; imm = v; opcode = opc; rd = rdv; funct3 = f3; rs1 = r1; rs2 = r2;
    in_valid = 1'b1;
    pend = '{modelEnc(f, v, opc, rdv, f3, r1, r2), modelErr(f, v), f, v, rt};
  endtask

  task automatic waitAccept();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail("accept_timeout");
    else begin
      sb.push_back(pend);
      nAcc++;
      if (pend.err) nErr++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] v, input logic [6:0] opc,
      input logic [4:0] rdv, input logic [2:0] f3, input logic [4:0] r1,
      input logic [4:0] r2, input bit rt);
    present(f, v, opc, rdv, f3, r1, r2, rt);
    waitAccept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || out_valid) fail("drain_timeout");
  endtask

  // Scoreboard pop and compare on every handshake; idle output must read zero
  always @(negedge clk) begin
    exp_t e;
    if (!rst && monEn) begin
      if (!out_valid) begin
        check("idle_instr", out_instr, 32'd0);
        check("idle_err", {31'd0, out_err}, 32'd0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          nAsserts++;
          nFails++;
          $error("FAIL unexpected_out observed=%h expected=none", out_instr);
        end else begin
          e = sb.pop_front();
          check("instr", out_instr, e.instr);
          check("err", {31'd0, out_err}, {31'd0, e.err});
          if (e.rt) check("roundtrip", decode(out_instr, e.fmt), e.imm);
        end
      end
    end
  end

  initial begin
    logic [31:0] expA;
    logic [2:0]  f;
    logic [31:0] v;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ext_op = 3'd0; imm = 32'd0; opcode = 7'd0; rd = 5'd0; funct3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    present(3'd0, 32'hFFFFF800, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 1'b1);
    pend.instr = 32'h80010093;
    pend.err = 1'b0;
    waitAccept();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_instr", out_instr, 32'h80010093);

    present(3'd3, 32'hFFFFFFFE, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 1'b1);
    pend.instr = 32'hFE000FE3;
    pend.err = 1'b0;
    waitAccept();
    check("b_lat_instr", out_instr, 32'hFE000FE3);

    send(3'd0, 32'd2048, 7'h13, 5'd3, 3'd1, 5'd4, 5'd0, 1'b0);
    send(3'd3, 32'd3, 7'h63, 5'd0, 3'd1, 5'd5, 5'd6, 1'b0);
    send(3'd7, 32'd5, 7'h13, 5'd7, 3'd2, 5'd8, 5'd0, 1'b0);
    send(3'd1, 32'h12345001, 7'h37, 5'd9, 3'd0, 5'd0, 5'd0, 1'b0);
    drain();
    check("err_cnt_4", {16'd0, err_cnt}, 32'd4);
    check("enc_cnt_6", {16'd0, enc_cnt}, 32'd6);

    send(3'd0, 32'd2047, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 1'b1);
    send(3'd0, -32'sd2048, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 1'b1);
    send(3'd2, -32'sd2049, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 1'b0);
    send(3'd3, 32'd4094, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 1'b1);
    send(3'd3, -32'sd4096, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 1'b1);
    send(3'd4, 32'd1048574, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 1'b1);
    send(3'd4, -32'sd1048576, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 1'b1);
    send(3'd4, 32'd1048576, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 1'b0);
    send(3'd1, 32'hABCDE000, 7'h37, 5'd2, 3'd0, 5'd0, 5'd0, 1'b1);
    drain();

    out_ready = 1'b0;
    present(3'd0, 32'd5, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 1'b1);
    expA = pend.instr;
    waitAccept();
    send(3'd2, 32'd12, 7'h23, 5'd0, 3'd2, 5'd3, 5'd4, 1'b1);
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    present(3'd4, 32'd100, 7'h6F, 5'd5, 3'd0, 5'd0, 5'd0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_head_stable", out_instr, expA);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitAccept();
    drain();

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 4));
      case (f)
        3'd0, 3'd2: v = 32'(int'($urandom_range(0, 4095)) - 2048);
        3'd3:       v = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        3'd4:       v = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
        default:    v = {$urandom() & 32'hFFFFF000};
      endcase
      send(f, v, 7'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()),
           5'($urandom()), 1'b1);
    end
    drain();
    check("enc_cnt_track", {16'd0, enc_cnt}, 32'(nAcc));
    check("err_cnt_track", {16'd0, err_cnt}, 32'(nErr));

    while (nAcc < 65535) send(3'd0, 32'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 1'b0);
    drain();
    check("enc_cnt_max", {16'd0, enc_cnt}, 32'h0000FFFF);
    send(3'd0, 32'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 1'b0);
    send(3'd0, 32'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 1'b0);
    drain();
    check("enc_cnt_sat", {16'd0, enc_cnt}, 32'h0000FFFF);

    out_ready = 1'b0;
    send(3'd0, 32'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 1'b0);
    send(3'd0, 32'd8, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 1'b0);
    present(3'd0, 32'd9, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_instr", out_instr, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_enc", {16'd0, enc_cnt}, 32'd0);
    check("mid_rst_err", {16'd0, err_cnt}, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_enc", {16'd0, enc_cnt}, 32'd0);
    out_ready = 1'b1;
    send(3'd1, 32'h00001000, 7'h37, 5'd3, 3'd0, 5'd0, 5'd0, 1'b1);
    drain();
    check("post_rst_enc1", {16'd0, enc_cnt}, 32'd1);

    monEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
